// File: rtl/umi_bank_ram.sv
// Multi-port, word-interleaved multi-bank UMI memory with per-bank arbitration
// and a 1-deep response register per port.
module umi_bank_ram #(
  parameter int unsigned N        = 2,
  parameter int unsigned NBANK    = 4,
  parameter int unsigned DW       = 64,
  parameter int unsigned AW       = 64,
  parameter int unsigned CW       = 32,
  parameter int unsigned RAMDEPTH = 1024
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              mode,
  input  logic [N-1:0]      udev_req_valid,
  input  logic [N*CW-1:0]   udev_req_cmd,
  input  logic [N*AW-1:0]   udev_req_dstaddr,
  input  logic [N*AW-1:0]   udev_req_srcaddr,
  input  logic [N*DW-1:0]   udev_req_data,
  output logic [N-1:0]      udev_req_ready,
  output logic [N-1:0]      udev_resp_valid,
  output logic [N*CW-1:0]   udev_resp_cmd,
  output logic [N*AW-1:0]   udev_resp_dstaddr,
  output logic [N*AW-1:0]   udev_resp_srcaddr,
  output logic [N*DW-1:0]   udev_resp_data,
  input  logic [N-1:0]      udev_resp_ready
);

  localparam int unsigned WOFF   = $clog2(DW / 8);
  localparam int unsigned NBL    = $clog2(NBANK);
  localparam int unsigned BSEL   = (NBANK > 1) ? NBL : 1;
  localparam int unsigned BDEPTH = RAMDEPTH / NBANK;
  localparam int unsigned RBITS  = $clog2(BDEPTH);
  localparam int unsigned ROFF   = WOFF + NBL;
  localparam int unsigned PW     = (N > 1) ? $clog2(N) : 1;

  logic [DW-1:0]    r_mem [NBANK][BDEPTH];
  logic [PW-1:0]    r_ptr [NBANK];
  logic [N-1:0]     r_resp_valid;
  logic [N*CW-1:0]  r_resp_cmd;
  logic [N*AW-1:0]  r_resp_dstaddr;
  logic [N*AW-1:0]  r_resp_srcaddr;
  logic [N*DW-1:0]  r_resp_data;

  logic [BSEL-1:0]  w_bank  [N];
  logic [RBITS-1:0] w_row   [N];
  logic [DW-1:0]    w_rdata [N];
  logic [N-1:0]     w_rd, w_wr, w_post, w_elig, w_grant;
  logic [PW-1:0]    w_idx;
  logic [NBANK-1:0] w_bfound, w_bwe;
  logic [PW-1:0]    w_bport [NBANK];
  logic [RBITS-1:0] w_brow  [NBANK];
  logic [DW-1:0]    w_bdata [NBANK];
  logic             w_unused_bits;

  function automatic int unsigned rr_idx(input int unsigned ptr, input int unsigned k,
                                         input logic m);
    rr_idx = m ? (ptr + 1 + k) % N : k;
  endfunction

  // Per-port address decode, opcode classification and eligibility
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_bank[i]  = (NBANK > 1) ? udev_req_dstaddr[i*AW+WOFF +: BSEL] : '0;
      w_row[i]   = udev_req_dstaddr[i*AW+ROFF +: RBITS];
      w_rd[i]    = udev_req_cmd[i*CW +: 5] == 5'h01;
      w_wr[i]    = udev_req_cmd[i*CW +: 5] == 5'h03;
      w_post[i]  = udev_req_cmd[i*CW +: 5] == 5'h05;
      w_elig[i]  = udev_req_valid[i] & (w_post[i] | ~r_resp_valid[i] | udev_resp_ready[i]);
      w_rdata[i] = r_mem[w_bank[i]][w_row[i]];
    end
  end

  // Per-bank arbitration; nothing is granted while reset is asserted
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      w_bfound[b] = 1'b0;
      w_bwe[b]    = 1'b0;
      w_bport[b]  = '0;
      w_brow[b]   = '0;
      w_bdata[b]  = '0;
    end
    if (nreset) begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        for (int unsigned k = 0; k < N; k++) begin
          w_idx = PW'(rr_idx(32'(r_ptr[b]), k, mode));
          if (!w_bfound[b] && w_elig[w_idx] && (w_bank[w_idx] == BSEL'(b))) begin
            w_bfound[b]    = 1'b1;
            w_bport[b]     = w_idx;
            w_grant[w_idx] = 1'b1;
            w_bwe[b]       = w_wr[w_idx] | w_post[w_idx];
            w_brow[b]      = w_row[w_idx];
            w_bdata[b]     = udev_req_data[w_idx*DW +: DW];
          end
        end
      end
    end
  end

  // Bank storage: not reset
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NBANK; b++) begin
      if (w_bwe[b]) r_mem[b][w_brow[b]] <= w_bdata[b];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned b = 0; b < NBANK; b++) r_ptr[b] <= PW'(N - 1);
    end else begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        if (w_bfound[b]) r_ptr[b] <= w_bport[b];
      end
    end
  end

  // Response slots: a new load wins over the clear from a consumed response
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_resp_valid   <= '0;
      r_resp_cmd     <= '0;
      r_resp_dstaddr <= '0;
      r_resp_srcaddr <= '0;
      r_resp_data    <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (w_grant[i] && (w_rd[i] || w_wr[i])) begin
          r_resp_valid[i]            <= 1'b1;
          r_resp_cmd[i*CW +: CW]     <= {udev_req_cmd[i*CW+5 +: CW-5], w_rd[i] ? 5'h02 : 5'h04};
          r_resp_dstaddr[i*AW +: AW] <= udev_req_srcaddr[i*AW +: AW];
          r_resp_srcaddr[i*AW +: AW] <= udev_req_dstaddr[i*AW +: AW];
          r_resp_data[i*DW +: DW]    <= w_rd[i] ? w_rdata[i] : '0;
        end else if (udev_resp_ready[i]) begin
          r_resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign udev_req_ready    = w_grant;
  assign udev_resp_valid   = r_resp_valid;
  assign udev_resp_cmd     = r_resp_cmd;
  assign udev_resp_dstaddr = r_resp_dstaddr;
  assign udev_resp_srcaddr = r_resp_srcaddr;
  assign udev_resp_data    = r_resp_data;

  // Size/len fields and aliased upper address bits are intentionally ignored
  assign w_unused_bits = ^{udev_req_cmd, udev_req_dstaddr};

endmodule

// File: tb/tb_umi_bank_ram.sv
// Self-checking bench for umi_bank_ram: vector table, scoreboard of expected
// responses, and hand sequences for arbitration, backpressure and reset.
module tb_umi_bank_ram;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;
  localparam int unsigned CW = 32;

  logic              clk = 1'b0;
  logic              nreset;
  logic              mode;
  logic [N-1:0]      udev_req_valid;
  logic [N*CW-1:0]   udev_req_cmd;
  logic [N*AW-1:0]   udev_req_dstaddr;
  logic [N*AW-1:0]   udev_req_srcaddr;
  logic [N*DW-1:0]   udev_req_data;
  logic [N-1:0]      udev_req_ready;
  logic [N-1:0]      udev_resp_valid;
  logic [N*CW-1:0]   udev_resp_cmd;
  logic [N*AW-1:0]   udev_resp_dstaddr;
  logic [N*AW-1:0]   udev_resp_srcaddr;
  logic [N*DW-1:0]   udev_resp_data;
  logic [N-1:0]      udev_resp_ready;

  always #5 clk = ~clk;

  umi_bank_ram #(.N(N), .NBANK(4), .DW(DW), .AW(AW), .CW(CW), .RAMDEPTH(1024)) dut (
    .clk(clk), .nreset(nreset), .mode(mode),
    .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
    .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
    .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
    .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
    .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
    .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready)
  );

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } resp_t;

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  op0, op1;
    logic [63:0] a0, a1, d0, d1;
    logic [1:0]  exp_rdy;
    string       name;
  } vec_t;

  resp_t       q0[$];
  resp_t       q1[$];
  logic [DW-1:0] mdl [int unsigned];
  int          tests = 0;
  int          fails = 0;
  int unsigned seq   = 0;
  logic [N-1:0]  s_ready, s_rvalid;
  logic [DW-1:0] s_rdata0;
  vec_t        tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_resp(input int p, input resp_t e);
    logic [CW-1:0] c;
    logic [AW-1:0] d, s;
    logic [DW-1:0] x;
    c = udev_resp_cmd[p*CW +: CW];
    d = udev_resp_dstaddr[p*AW +: AW];
    s = udev_resp_srcaddr[p*AW +: AW];
    x = udev_resp_data[p*DW +: DW];
    tests++;
    if ({c, d, s, x} !== {e.cmd, e.dst, e.src, e.data}) begin
      fails++;
      $display("FAIL resp_p%0d: got cmd=%h dst=%h src=%h data=%h required cmd=%h dst=%h src=%h data=%h",
               p, c, d, s, x, e.cmd, e.dst, e.src, e.data);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [4:0] op,
                         input logic [63:0] addr, input logic [63:0] data);
    seq++;
    udev_req_valid[p]            = v;
    udev_req_cmd[p*CW +: CW]     = {27'(seq), op};
    udev_req_dstaddr[p*AW +: AW] = addr;
    udev_req_srcaddr[p*AW +: AW] = 64'hC000_0000_0000_0000 | 64'(seq << 8) | 64'(p);
    udev_req_data[p*DW +: DW]    = data;
  endtask

  // One clock: sample outputs mid-low-phase, score responses, model requests
  task automatic cycle();
    resp_t       e;
    logic [4:0]  op;
    logic [AW-1:0] a;
    int unsigned key;
    #1;
    s_ready  = udev_req_ready;
    s_rvalid = udev_resp_valid;
    s_rdata0 = udev_resp_data[DW-1:0];
    for (int p = 0; p < N; p++) begin
      if (udev_resp_valid[p] && udev_resp_ready[p]) begin
        if ((p == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL resp_unexpected: port %0d valid=1 required no response", p);
        end else begin
          e = (p == 0) ? q0.pop_front() : q1.pop_front();
          chk_resp(p, e);
        end
      end
    end
    for (int p = 0; p < N; p++) begin
      if (udev_req_valid[p] && udev_req_ready[p]) begin
        op     = udev_req_cmd[p*CW +: 5];
        a      = udev_req_dstaddr[p*AW +: AW];
        key    = 32'(a[12:3]);
        e.cmd  = {udev_req_cmd[p*CW+5 +: CW-5], (op == 5'h01) ? 5'h02 : 5'h04};
        e.dst  = udev_req_srcaddr[p*AW +: AW];
        e.src  = a;
        e.data = '0;
        if (op == 5'h03 || op == 5'h05) mdl[key] = udev_req_data[p*DW +: DW];
        if (op == 5'h01) e.data = mdl.exists(key) ? mdl[key] : 'x;
        if (op == 5'h01 || op == 5'h03) begin
          if (p == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    udev_req_valid  = '0;
    udev_resp_ready = '1;
    repeat (3) cycle();
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b01, 5'h03, 5'h00, 64'h40,   64'h0,    64'hA5A5, 64'h0,  2'b01, "wr40"};
    tbl[1]  = '{2'b01, 5'h01, 5'h00, 64'h40,   64'h0,    64'h0,    64'h0,  2'b01, "rd40"};
    tbl[2]  = '{2'b11, 5'h03, 5'h03, 64'h00,   64'h08,   64'h11,   64'h22, 2'b11, "wr_b0_b1"};
    tbl[3]  = '{2'b11, 5'h01, 5'h01, 64'h00,   64'h08,   64'h0,    64'h0,  2'b11, "rd_b0_b1"};
    tbl[4]  = '{2'b11, 5'h03, 5'h03, 64'h10,   64'h10,   64'h33,   64'h44, 2'b01, "wr_conflict"};
    tbl[5]  = '{2'b10, 5'h00, 5'h03, 64'h0,    64'h18,   64'h0,    64'h55, 2'b10, "wr_p1"};
    tbl[6]  = '{2'b11, 5'h07, 5'h01, 64'h20,   64'h18,   64'h0,    64'h0,  2'b11, "badop"};
    tbl[7]  = '{2'b11, 5'h05, 5'h01, 64'h28,   64'h28,   64'h77,   64'h0,  2'b01, "posted_conflict"};
    tbl[8]  = '{2'b11, 5'h01, 5'h01, 64'h28,   64'h10,   64'h0,    64'h0,  2'b11, "rd_posted"};
    tbl[9]  = '{2'b01, 5'h03, 5'h00, 64'h00,   64'h0,    64'h1234, 64'h0,  2'b01, "wr0"};
    tbl[10] = '{2'b10, 5'h00, 5'h01, 64'h0,    64'h2000, 64'h0,    64'h0,  2'b10, "rd_alias"};

    nreset           = 1'b0;
    mode             = 1'b0;
    udev_req_valid   = '0;
    udev_req_cmd     = '0;
    udev_req_dstaddr = '0;
    udev_req_srcaddr = '0;
    udev_req_data    = '0;
    udev_resp_ready  = '1;

    // Reset state, with a request present
    set_req(0, 1'b1, 5'h01, 64'h40, 64'h0);
    @(negedge clk);
    #1;
    chk("rst_req_ready",  64'(udev_req_ready), 64'd0);
    chk("rst_resp_valid", 64'(udev_resp_valid), 64'd0);
    chk("rst_resp_cmd",   64'(udev_resp_cmd), 64'd0);
    chk("rst_resp_dst",   64'(|udev_resp_dstaddr), 64'd0);
    chk("rst_resp_src",   64'(|udev_resp_srcaddr), 64'd0);
    chk("rst_resp_data",  64'(|udev_resp_data), 64'd0);
    @(negedge clk);
    udev_req_valid = '0;
    nreset = 1'b1;
    @(negedge clk);

    // Vector table, fixed priority, responses always accepted
    for (int i = 0; i < 11; i++) begin
      set_req(0, tbl[i].v[0], tbl[i].op0, tbl[i].a0, tbl[i].d0);
      set_req(1, tbl[i].v[1], tbl[i].op1, tbl[i].a1, tbl[i].d1);
      cycle();
      chk(tbl[i].name, 64'(s_ready), 64'(tbl[i].exp_rdy));
    end
    drain();

    // Backpressure on port 0
    udev_resp_ready = 2'b10;
    set_req(0, 1'b1, 5'h01, 64'h08, 64'h0);
    cycle();
    chk("bp_first_rdy", 64'(s_ready[0]), 64'd1);
    set_req(0, 1'b1, 5'h01, 64'h00, 64'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_rdy",   64'(s_ready[0]), 64'd0);
      chk("bp_hold_valid", 64'(s_rvalid[0]), 64'd1);
      chk("bp_hold_data",  s_rdata0, 64'h22);
    end
    set_req(0, 1'b1, 5'h05, 64'h48, 64'h99);
    cycle();
    chk("bp_posted_rdy", 64'(s_ready[0]), 64'd1);
    chk("bp_posted_data", s_rdata0, 64'h22);
    udev_req_valid  = '0;
    udev_resp_ready = '1;
    cycle();
    set_req(0, 1'b1, 5'h01, 64'h48, 64'h0);
    cycle();
    drain();

    // Reset with a pending response; a write attempted during reset must not land
    set_req(0, 1'b1, 5'h01, 64'h40, 64'h0);
    cycle();
    udev_req_valid = '0;
    #1;
    chk("rst_mid_pre_valid", 64'(udev_resp_valid[0]), 64'd1);
    nreset = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(udev_resp_valid), 64'd0);
    q0.delete();
    q1.delete();
    set_req(1, 1'b1, 5'h03, 64'h48, 64'hDEAD);
    #1;
    chk("rst_mid_rdy", 64'(udev_req_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    udev_req_valid = '0;
    nreset = 1'b1;
    set_req(0, 1'b1, 5'h01, 64'h48, 64'h0);
    cycle();
    udev_req_valid = '0;
    set_req(1, 1'b1, 5'h01, 64'h28, 64'h0);
    cycle();
    drain();

    // Round-robin hammer on bank 0: alternation starts at port 0 after reset
    mode = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, 5'h01, 64'h00, 64'h0);
      set_req(1, 1'b1, 5'h01, 64'h40, 64'h0);
      cycle();
      chk("rr_grant", 64'(s_ready), (c % 2 == 0) ? 64'd1 : 64'd2);
    end
    mode = 1'b0;
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1'b1, 5'h01, 64'h00, 64'h0);
      set_req(1, 1'b1, 5'h01, 64'h40, 64'h0);
      cycle();
      chk("fixed_grant", 64'(s_ready), 64'd1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
